// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered UART transmitter: a small FIFO of ASCII bytes feeding an 8N1
// serializer running at DIV = CLK_HZ/BAUD clock cycles per bit.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the last data bit and the stop bit (frame becomes 11 bit periods).
//
// Handshake: push/din form a one-cycle valid strobe. The ready side is
// ~tx_busy, a registered FIFO-full flag. A push is taken on the clock edge
// where push=1 and tx_busy=0; a push seen while tx_busy=1 is dropped and
// latches the sticky overflow flag. tx_busy reflects every push/pop from the
// cycle after the edge that caused it.

module uart_tx_buffered #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       empty,
    output logic       overflow,
    output logic       tx_done,
    output logic [2:0] dbg_state
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0]      DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]            mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic                  push_ok;
    logic                  pop;

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             tx_d;
    logic             done_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_q;
    logic             par_d;
`endif

    // Push is accepted against the registered full flag, even when a pop
    // happens on the same edge; this keeps the ready path fully registered.
    assign push_ok   = push & ~tx_busy;
    assign bit_end   = (cnt_q == DIV_LAST);
    assign dbg_state = state_q;

    // Next occupancy: push and pop on the same edge cancel out.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO data array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy, registered full/empty and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            tx_busy  <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && tx_busy) begin
                overflow <= 1'b1;
            end
            count_q <= count_d;
            tx_busy <= (count_d == FULL_CNT);
            empty   <= (count_d == '0);
        end
    end

    // Serializer next-state: the line value for the next cycle is computed
    // here so that tx itself can be a plain register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    par_d   = ^mem[rd_ptr];
`endif
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d = par_q;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Serializer registers; reset aborts any frame and returns the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            tx_done <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the byte in flight, captured at pop time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered
// Bench for uart_tx_buffered with DIV=10 and a 4-entry FIFO. Bytes are
// queued in exp_q as they are pushed; a line receiver decodes every frame on
// tx and compares it with the head of exp_q. Honours UART_TX_PARITY_EN.

module tb_uart_tx_buffered;

    localparam int CLK_HZ     = 1_000_000;
    localparam int BAUD       = 100_000;
    localparam int DIV        = 10;
    localparam int DEPTH_LOG2 = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS      = 11;
`else
    localparam int NBITS      = 10;
`endif
    localparam int FRAME      = NBITS * DIV;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] din;
    logic       tx;
    logic       tx_busy;
    logic       empty;
    logic       overflow;
    logic       tx_done;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .din       (din),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .empty     (empty),
        .overflow  (overflow),
        .tx_done   (tx_done),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    int         checks     = 0;
    int         errors     = 0;
    int         frames_rx  = 0;
    bit         abort_flag = 1'b0;

    logic [7:0] mon_b;
    logic       mon_start;
    logic       mon_stop;
    logic       mon_par;
    logic [7:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Line receiver: samples each bit mid-period on the falling clock edge
    // ------------------------------------------------------------------
    initial begin
        mon_par = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                repeat (DIV / 2 - 1) @(negedge clk);
                mon_start = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    mon_b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                mon_par = tx;
`endif
                repeat (DIV) @(negedge clk);
                mon_stop = tx;
                if (abort_flag) begin
                    abort_flag = 1'b0;
                end else begin
                    frames_rx++;
                    check("start_bit", mon_start, 0);
                    check("stop_bit", mon_stop, 1);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", mon_par, ^mon_b);
`endif
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_exp = exp_q.pop_front();
                        check("frame_data", mon_b, mon_exp);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Sender-style push: wait for ready, pulse push for one cycle.
    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (tx_busy && w < 4 * FRAME) begin
            @(negedge clk);
            w++;
        end
        check("busy_wait_bounded", w < 4 * FRAME, 1);
        push = 1'b1;
        din  = b;
        exp_q.push_back(b);
        @(negedge clk);
        push = 1'b0;
    endtask

    // Wait for the receiver to consume every expected byte, then let the
    // last stop bit and IDLE cycle pass before checking the FIFO flags.
    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 40 * (FRAME + 1)) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (2 * DIV) @(negedge clk);
        check("drain_empty", empty, 1);
        check("drain_busy", tx_busy, 0);
        check("drain_tx_idle", tx, 1);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [10:0] fb;
        logic [7:0]  fill [0:5];
        string       msg;
        int          done_cnt;
        int          done_at;
        int          frames_before;

        rst  = 1'b1;
        push = 1'b0;
        din  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_empty", empty, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", tx_done, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;

        // Idle for 100 cycles with no push
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 25 == 24) begin
                check("idle_tx", tx, 1);
                check("idle_empty", empty, 1);
                check("idle_busy", tx_busy, 0);
                check("idle_overflow", overflow, 0);
            end
        end

        // Single byte 0x54: exact line timing and tx_done position
        fb = frame_bits(8'h54);
        @(negedge clk);
        push = 1'b1;
        din  = 8'h54;
        exp_q.push_back(8'h54);
        @(posedge clk);
        #1;
        push = 1'b0;
        check("push_clears_empty", empty, 0);
        check("tx_high_before_pop", tx, 1);
        @(posedge clk);
        done_cnt = 0;
        done_at  = -1;
        for (int k = 0; k < FRAME + 5; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            if (k < FRAME && (k % DIV == 0 || k % DIV == DIV - 1)) begin
                check("frame_bit_0x54", tx, fb[k / DIV]);
            end
            if (tx_done) begin
                done_cnt++;
                done_at = k;
            end
        end
        check("tx_done_count", done_cnt, 1);
        check("tx_done_cycle", done_at, FRAME);
        drain();

        // Fill a 4-deep FIFO with 5 back-to-back pushes, 6th overflows
        for (int i = 0; i < 6; i++) fill[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fill_busy", tx_busy, (i == 5) ? 1 : 0);
            check("fill_overflow", overflow, 0);
            push = 1'b1;
            din  = fill[i];
            if (i < 5) exp_q.push_back(fill[i]);
        end
        @(negedge clk);
        push = 1'b0;
        check("overflow_set", overflow, 1);
        check("full_busy", tx_busy, 1);
        drain();
        check("overflow_sticky", overflow, 1);

        // A sender-style message, tx_busy polled between bytes
        frames_before = frames_rx;
        msg = "TIME = 12:34:56:78\n";
        for (int i = 0; i < msg.len(); i++) send_byte(msg[i]);
        drain();
        check("message_frames", frames_rx - frames_before, 19);

        // Pointer wrap-around: 3*DEPTH paced bytes
        frames_before = frames_rx;
        for (int i = 0; i < 12; i++) send_byte(8'($urandom_range(0, 255)));
        drain();
        check("wrap_frames", frames_rx - frames_before, 12);

        // Reset during DATA bit 3 with 3 bytes still queued
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        repeat (39) @(negedge clk);
        check("abort_in_data", dbg_state, 2);
        frames_before = frames_rx;
        abort_flag = 1'b1;
        rst = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_empty", empty, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_overflow", overflow, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4 * FRAME) @(negedge clk);
        check("abort_no_frames", frames_rx - frames_before, 0);
        check("abort_tx_idle", tx, 1);
        check("abort_still_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered 8N1 UART transmitter that sits directly downstream of the ASCII sender blocks. It accepts one-cycle `push` pulses carrying an ASCII byte into a small FIFO. It serializes the buffered bytes onto `tx` at a fixed baud rate and returns `tx_busy` as the back-pressure signal the sender polls. This lets a whole message (up to 25 bytes) be queued in bursts while the line drains at baud speed.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate; bit period `DIV = CLK_HZ/BAUD` cycles (integer division, DIV ≥ 2)
- `DEPTH_LOG2`, 4, FIFO depth = 2**DEPTH_LOG2 entries
- Reset `rst`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `push`  in  1  one-cycle write strobe (connects to sender `send_start`)
- `din`  in  8  byte captured when `push`=1 (connects to sender `ascii_data`)
- `tx`  out  1  serial line, idle high
- `tx_busy`  out  1  FIFO full, registered (connects to sender `tx_busy`)
- `empty`  out  1  FIFO empty, registered
- `overflow`  out  1  sticky: a push was dropped while full
- `tx_done`  out  1  one-cycle pulse at the end of each frame's stop bit

## Operation
- FIFO: write pointer, read pointer (DEPTH_LOG2 bits, natural wrap-around) and occupancy count (DEPTH_LOG2+1 bits). `tx_busy` = (count == DEPTH); `empty` = (count == 0). Both are registered from the count.
- Push accepted iff `push`=1 and `tx_busy`=0 (registered value), even if a pop occurs in the same cycle. A rejected push sets `overflow`, which is cleared only by `rst`.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: `tx`=1. If `empty`=0, pop the head byte into an 8-bit shift register, clear the baud counter, go to START.
  - START: `tx`=0 for DIV cycles.
  - DATA: drive shift[0], LSB first, 8 bits, DIV cycles each, with a bit index counter from 0 to 7.
  - STOP: `tx`=1 for DIV cycles. On the last cycle, pulse `tx_done` and go to IDLE.
- Baud counter counts 0..DIV-1. It is advanced only outside IDLE and wraps on each bit boundary.
- `tx` is driven from a register (glitch-free).
- Reset values: `tx`=1, `tx_busy`=0, `empty`=1, `overflow`=0, `tx_done`=0, FSM=IDLE, pointers, count and counters = 0.
- Reset asserted mid-frame aborts the frame immediately: `tx`=1 and the FIFO contents are discarded.

## Timing
- An accepted push at edge E0 sets `empty`=0 after E0. The pop occurs at E1, and `tx` goes low from E1.
- Push-to-line latency is therefore 1 cycle after the capture edge, when the FIFO was empty and the FSM was in IDLE.
- Frame length is 10·DIV cycles (11·DIV with parity).
- There is a mandatory single IDLE cycle between back-to-back frames, so frame pitch = 10·DIV+1 cycles.
- `tx_busy` reflects a push or pop of edge En from cycle n+1 onward. This suits the sender's pulse-then-check pattern, in which it tests `tx_busy` one cycle after its `send_start` pulse.
- Pop and push on the same edge when full: the pop is applied and the push is dropped (`overflow`=1).

## Configuration
- `UART_TX_PARITY_EN` defined: adds the PARITY state between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for DIV cycles.
  - Frame becomes 11·DIV cycles.
- Undefined: no PARITY state; 8N1 frame of 10·DIV cycles.

## Test plan
- Reset then idle: `tx`=1, `empty`=1, `tx_busy`=0, `overflow`=0 held for 100 cycles with no push.
- CLK_HZ=1_000_000, BAUD=100_000 (DIV=10), single push of 0x54:
  - `tx` sequence is 0 | 0,0,1,0,1,0,1,0 | 1, each bit held for 10 cycles.
  - `tx_done` pulses once at cycle 100 after the pop.
  - With `UART_TX_PARITY_EN`, a parity bit of 1 is inserted before stop.
- DEPTH_LOG2=2: push 5 bytes on consecutive cycles.
  - `tx_busy` rises after the 5th accepted byte: byte 1 is popped immediately, so 4 bytes are held.
  - The 6th push sets `overflow`=1.
  - The line carries exactly the first 5 bytes in order.
- Connect an ascii_sender_watch instance with start=1 for one cycle. The line carries exactly 19 frames, "TIME = hh:mm:ss:cc\n", with no byte lost, duplicated or reordered.
- Wrap-around: 3·DEPTH bytes pushed at pace with `tx_busy` respected. All are received in order, and `empty`=1 after the last `tx_done`.
- Assert `rst` during DATA bit 3 with 3 bytes queued: `tx`=1 immediately, `empty`=1, and no further frames after release.
